// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding fetch at a time on
// the instruction bus and presents {pc, inst, valid} to IF/ID with a one-entry hold buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        stallreq_from_if_o,
  output logic [2:0]  fsm_state
);

  // Handshake: the bus accepts a request in any cycle where ibus_req_o && ibus_gnt_i;
  // an ungranted request may change address; exactly one ibus_rvalid_i follows each
  // grant, no earlier than the next cycle. The consumer takes the presented
  // instruction in any cycle where if_valid_o && !stall_i[1].

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  logic [31:0] flush_pc;
  logic        hold_req;
  logic        unused_bits;

  assign flush_pc    = {new_pc_i[31:2], 2'b00};
  assign hold_req    = stall_i[1];
  assign unused_bits = &{1'b0, stall_i[5:2], stall_i[0], new_pc_i[1:0]};

  assign ibus_addr_o = pc_q;
  assign fsm_state   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      hold_pc_q   <= 32'd0;
      hold_inst_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    hold_pc_d          = hold_pc_q;
    hold_inst_d        = hold_inst_q;
    ibus_req_o         = 1'b0;
    stallreq_from_if_o = 1'b0;
    if_valid_o         = 1'b0;
    if_pc_o            = 32'd0;
    if_inst_o          = 32'd0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (flush_i) pc_d = flush_pc;
      end

      REQ: begin
        ibus_req_o         = 1'b1;
        stallreq_from_if_o = 1'b1;
        if (flush_i) begin
          pc_d    = flush_pc;
          state_d = ibus_gnt_i ? DISCARD : REQ;
        end else if (ibus_gnt_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        stallreq_from_if_o = !ibus_rvalid_i;
        if (flush_i) begin
          pc_d    = flush_pc;
          state_d = ibus_rvalid_i ? REQ : DISCARD;
        end else if (ibus_rvalid_i) begin
          if_valid_o = 1'b1;
          if_pc_o    = pc_q;
          if_inst_o  = ibus_rdata_i;
          if (!hold_req) begin
            pc_d    = pc_q + PC_INC;
            state_d = REQ;
          end else begin
            hold_pc_d   = pc_q;
            hold_inst_d = ibus_rdata_i;
            state_d     = HOLD;
          end
        end
      end

      HOLD: begin
        if_valid_o = 1'b1;
        if_pc_o    = hold_pc_q;
        if_inst_o  = hold_inst_q;
        // Flush beats consume: the held instruction is dropped, not retired.
        if (flush_i || !hold_req) begin
          hold_pc_d   = 32'd0;
          hold_inst_d = 32'd0;
          pc_d        = flush_i ? flush_pc : pc_q + PC_INC;
          state_d     = REQ;
        end
      end

      DISCARD: begin
        stallreq_from_if_o = 1'b1;
        if (flush_i) pc_d = flush_pc;
        if (ibus_rvalid_i) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
